// File: rtl/ps2_pkg.sv
// Shared scan-code constants, FSM encoding and key decode for the PS/2 key controller.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  // Prefix FSM: which prefixes have been seen for the sequence in flight
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StExt    = 2'd1,
    StBrk    = 2'd2,
    StExtBrk = 2'd3
  } ps2_state_e;

  typedef enum logic [2:0] {
    KeyNone  = 3'd0,
    KeyW     = 3'd1,
    KeyS     = 3'd2,
    KeySpace = 3'd3,
    KeyEsc   = 3'd4,
    KeyUp    = 3'd5,
    KeyDown  = 3'd6
  } key_e;

  // Map a final code byte to a tracked key; arrow codes only count when extended
  function automatic key_e decode_key(input logic ext, input logic [7:0] code);
    key_e k;
    k = KeyNone;
    if (ext) begin
      if (code == SC_UP) begin
        k = KeyUp;
      end else if (code == SC_DOWN) begin
        k = KeyDown;
      end
    end else begin
      case (code)
        SC_W:     k = KeyW;
        SC_S:     k = KeyS;
        SC_SPACE: k = KeySpace;
        SC_ESC:   k = KeyEsc;
        default:  k = KeyNone;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/paddle_dir_resolver.sv
// Resolves one player's up/down held flags into registered paddle directions.
// Optional feature macro: SOCD_LAST_WINS_EN (both held -> last pressed wins).
// Without it, both held resolves to neutral.
// Inputs are next-state held flags and make-edge strobes, so the registered
// outputs line up with the held-flag registers in the parent.
module paddle_dir_resolver (
  input  logic clk,
  input  logic rst,
  input  logic up_held,
  input  logic dn_held,
  input  logic up_make,
  input  logic dn_make,
  output logic dir_up,
  output logic dir_dn
);

  logic dir_up_q, dir_up_d;
  logic dir_dn_q, dir_dn_d;

`ifdef SOCD_LAST_WINS_EN
  logic last_up_q, last_up_d;

  // Track which direction was most recently newly pressed
  always_comb begin
    last_up_d = last_up_q;
    if (up_make) begin
      last_up_d = 1'b1;
    end else if (dn_make) begin
      last_up_d = 1'b0;
    end
  end

  // Last-pressed register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_up_q <= 1'b0;
    end else begin
      last_up_q <= last_up_d;
    end
  end

  // Conflict goes to the most recent press
  always_comb begin
    dir_up_d = up_held & (~dn_held | last_up_d);
    dir_dn_d = dn_held & (~up_held | ~last_up_d);
  end
`else
  logic unused_make;
  assign unused_make = up_make | dn_make;

  // Conflict resolves to neutral
  always_comb begin
    dir_up_d = up_held & ~dn_held;
    dir_dn_d = dn_held & ~up_held;
  end
`endif

  // Direction output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_up_q <= 1'b0;
      dir_dn_q <= 1'b0;
    end else begin
      dir_up_q <= dir_up_d;
      dir_dn_q <= dir_dn_d;
    end
  end

  assign dir_up = dir_up_q;
  assign dir_dn = dir_dn_q;

endmodule

// File: rtl/ps2_key_controller.sv
// Scan-code set 2 decoder between the PS/2 byte receiver and the Pong game FSM.
// Tracks held keys and drives paddle directions, start pulse, pause toggle and
// a sequence-timeout error pulse.
// Optional feature macro: SOCD_LAST_WINS_EN (handled in paddle_dir_resolver).
module ps2_key_controller
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 250000,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       p1_up,
  output logic       p1_down,
  output logic       p2_up,
  output logic       p2_down,
  output logic       start_pulse,
  output logic       paused,
  output logic       seq_err
);

  logic             rx_valid_q;
  logic             accept;
  ps2_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;

  logic             ev_make, ev_break, ev_ext;
  key_e             ev_key;

  logic w_q, w_d, s_q, s_d, up_q, up_d, dn_q, dn_d, space_q, space_d, esc_q, esc_d;
  logic w_rise, s_rise, up_rise, dn_rise, space_rise, esc_rise;
  logic start_q, start_d, paused_q, paused_d, seq_err_q, seq_err_d;

  // Rising edge of the receiver flag: one accept per byte
  assign accept = rx_valid & ~rx_valid_q;

  // A byte arriving on the expiry cycle takes priority over the timeout
  assign timeout = (state_q != StIdle) && !accept &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Receiver flag delay register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
    end
  end

  // FSM state and timeout counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Prefix FSM next state and timeout counter
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = StIdle;
    end else if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (rx_data == SC_EXT) begin
            state_d = StExt;
          end else if (rx_data == SC_BRK) begin
            state_d = StBrk;
          end
        end
        StExt: begin
          if (rx_data == SC_BRK) begin
            state_d = StExtBrk;
          end else if (rx_data != SC_EXT) begin
            state_d = StIdle;
          end
        end
        StBrk: begin
          if (rx_data != SC_BRK) begin
            state_d = StIdle;
          end
        end
        StExtBrk: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end

    if ((state_q == StIdle) || accept || timeout) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // FSM outputs: classify the accepted byte as a make or break event
  always_comb begin
    ev_make  = 1'b0;
    ev_break = 1'b0;
    ev_ext   = 1'b0;
    if (accept) begin
      unique case (state_q)
        StIdle:   ev_make = (rx_data != SC_EXT) && (rx_data != SC_BRK);
        StExt: begin
          ev_make = (rx_data != SC_EXT) && (rx_data != SC_BRK);
          ev_ext  = 1'b1;
        end
        StBrk:    ev_break = (rx_data != SC_BRK);
        StExtBrk: begin
          ev_break = 1'b1;
          ev_ext   = 1'b1;
        end
        default: ;
      endcase
    end
    ev_key = decode_key(ev_ext, rx_data);
  end

  // Held-flag next state, make edges and game control next state
  always_comb begin
    w_d     = w_q;
    s_d     = s_q;
    up_d    = up_q;
    dn_d    = dn_q;
    space_d = space_q;
    esc_d   = esc_q;
    if (ev_make || ev_break) begin
      case (ev_key)
        KeyW:     w_d     = ev_make;
        KeyS:     s_d     = ev_make;
        KeySpace: space_d = ev_make;
        KeyEsc:   esc_d   = ev_make;
        KeyUp:    up_d    = ev_make;
        KeyDown:  dn_d    = ev_make;
        default: ;
      endcase
    end

    // Typematic repeats of a held key produce no edge
    w_rise     = w_d & ~w_q;
    s_rise     = s_d & ~s_q;
    up_rise    = up_d & ~up_q;
    dn_rise    = dn_d & ~dn_q;
    space_rise = space_d & ~space_q;
    esc_rise   = esc_d & ~esc_q;

    start_d   = space_rise;
    paused_d  = paused_q ^ esc_rise;
    seq_err_d = timeout;
  end

  // Held flags and game control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_q       <= 1'b0;
      s_q       <= 1'b0;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      space_q   <= 1'b0;
      esc_q     <= 1'b0;
      start_q   <= 1'b0;
      paused_q  <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      w_q       <= w_d;
      s_q       <= s_d;
      up_q      <= up_d;
      dn_q      <= dn_d;
      space_q   <= space_d;
      esc_q     <= esc_d;
      start_q   <= start_d;
      paused_q  <= paused_d;
      seq_err_q <= seq_err_d;
    end
  end

  paddle_dir_resolver u_p1_dir (
    .clk     (clk),
    .rst     (rst),
    .up_held (w_d),
    .dn_held (s_d),
    .up_make (w_rise),
    .dn_make (s_rise),
    .dir_up  (p1_up),
    .dir_dn  (p1_down)
  );

  paddle_dir_resolver u_p2_dir (
    .clk     (clk),
    .rst     (rst),
    .up_held (up_d),
    .dn_held (dn_d),
    .up_make (up_rise),
    .dn_make (dn_rise),
    .dir_up  (p2_up),
    .dir_dn  (p2_down)
  );

  assign start_pulse = start_q;
  assign paused      = paused_q;
  assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_ps2_key_controller.sv
// Self-checking bench for ps2_key_controller with a sequence-level key model.
// Honours SOCD_LAST_WINS_EN when compiled with it.
module tb_ps2_key_controller;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       p1_up, p1_down, p2_up, p2_down, start_pulse, paused, seq_err;

  int tests = 0;
  int fails = 0;

  // Reference model: held keys by index 0 W, 1 S, 2 Up, 3 Down, 4 Space, 5 Esc
  bit m_held [6];
  bit m_last_up [2];
  bit m_paused;
  bit m_ext, m_brk;
  bit m_pulse;

  int sp_seen = 0;
  int se_seen = 0;

  ps2_key_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .p1_up       (p1_up),
    .p1_down     (p1_down),
    .p2_up       (p2_up),
    .p2_down     (p2_down),
    .start_pulse (start_pulse),
    .paused      (paused),
    .seq_err     (seq_err)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (start_pulse === 1'b1) sp_seen++;
    if (seq_err === 1'b1) se_seen++;
  end

  function automatic int key_of(input bit ext, input logic [7:0] code);
    if (ext) begin
      if (code == 8'h75) return 2;
      if (code == 8'h72) return 3;
      return -1;
    end
    if (code == 8'h1D) return 0;
    if (code == 8'h1B) return 1;
    if (code == 8'h29) return 4;
    if (code == 8'h76) return 5;
    return -1;
  endfunction

  function automatic logic [1:0] resolve(input bit u, input bit d, input bit last_up);
    if (u && d) begin
`ifdef SOCD_LAST_WINS_EN
      return last_up ? 2'b10 : 2'b01;
`else
      return (last_up && !last_up) ? 2'b11 : 2'b00;
`endif
    end
    return {u, d};
  endfunction

  function automatic logic [4:0] expected();
    return {resolve(m_held[0], m_held[1], m_last_up[0]),
            resolve(m_held[2], m_held[3], m_last_up[1]), m_paused};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_held[i] = 1'b0;
    m_last_up[0] = 1'b0;
    m_last_up[1] = 1'b0;
    m_paused = 1'b0;
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_pulse = 1'b0;
  endtask

  // Sequence-level interpretation of one received byte
  task automatic model_byte(input logic [7:0] b);
    int k;
    m_pulse = 1'b0;
    if (!m_brk && b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0 && !(m_ext && m_brk)) begin
      m_brk = 1'b1;
    end else begin
      k = key_of(m_ext, b);
      if (k >= 0) begin
        if (!m_brk) begin
          if (!m_held[k]) begin
            if (k == 4) m_pulse = 1'b1;
            if (k == 5) m_paused = !m_paused;
            if (k < 2) m_last_up[0] = (k == 0);
            else if (k < 4) m_last_up[1] = (k == 2);
          end
          m_held[k] = 1'b1;
        end else begin
          m_held[k] = 1'b0;
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic check_out(input string tag);
    logic [4:0] obs;
    logic [4:0] exp_v;
    obs   = {p1_up, p1_down, p2_up, p2_down, paused};
    exp_v = expected();
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s outputs {p1u,p1d,p2u,p2d,paused} got=%b want=%b", tag, obs, exp_v);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s got=%b want=%b", tag, obs, exp_v);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp_v);
    tests++;
    assert (obs == exp_v) else begin
      fails++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, exp_v);
    end
  endtask

  // Present one byte with rx_valid high for 'hold' cycles; check one cycle after accept
  task automatic send(input logic [7:0] b, input int hold, input string tag);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    model_byte(b);
    check_out(tag);
    check_bit({tag, " start"}, start_pulse, m_pulse);
    check_bit({tag, " seq_err"}, seq_err, 1'b0);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      check_out({tag, " hold"});
      check_bit({tag, " start hold"}, start_pulse, 1'b0);
    end
    rx_valid = 1'b0;
  endtask

  logic [7:0] pool [10];
  int sp0, se0, hit, se_exp;

  initial begin
    pool = '{8'h1D, 8'h1B, 8'h29, 8'h76, 8'h75, 8'h72, 8'hE0, 8'hF0, 8'hE1, 8'h12};
    se_exp   = 0;
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check_out("reset");
    check_bit("reset start", start_pulse, 1'b0);
    check_bit("reset seq_err", seq_err, 1'b0);
    rst = 1'b1;

    // Long rx_valid, then break
    send(8'h1D, 5, "w make long valid");
    send(8'hF0, 1, "w brk prefix");
    send(8'h1D, 1, "w break");

    // Extended up arrow and bare keypad code
    send(8'hE0, 1, "up ext");
    send(8'h75, 1, "up make");
    send(8'hE0, 1, "up ext2");
    send(8'hF0, 1, "up brk");
    send(8'h75, 1, "up break");
    send(8'h75, 1, "bare 75");
    send(8'h72, 1, "bare 72");

    // Typematic space and esc toggling
    sp0 = sp_seen;
    send(8'h29, 1, "space 1");
    send(8'h29, 2, "space 2");
    send(8'h29, 1, "space 3");
    send(8'hF0, 1, "space brk");
    send(8'h29, 1, "space break");
    repeat (2) @(negedge clk);
    check_int("start pulse count", sp_seen - sp0, 1);
    send(8'h76, 1, "esc make 1");
    send(8'h76, 1, "esc repeat");
    send(8'hF0, 1, "esc brk 1");
    send(8'h76, 1, "esc break 1");
    send(8'h76, 1, "esc make 2");
    send(8'hF0, 1, "esc brk 2");
    send(8'h76, 1, "esc break 2");

    // Simultaneous opposing directions
    send(8'h1D, 1, "w hold");
    send(8'h1B, 1, "s hold both");
    send(8'hF0, 1, "s brk");
    send(8'h1B, 1, "s break w remains");
    send(8'hF0, 1, "w brk");
    send(8'h1D, 1, "w release");
    send(8'hE0, 1, "p2 ext a");
    send(8'h72, 1, "down hold");
    send(8'hE0, 1, "p2 ext b");
    send(8'h75, 1, "up hold both");
    send(8'hE0, 1, "p2 ext c");
    send(8'hF0, 1, "p2 brk c");
    send(8'h75, 1, "up break down remains");
    send(8'hE0, 1, "p2 ext d");
    send(8'hF0, 1, "p2 brk d");
    send(8'h72, 1, "down release");

    // Prefix timeout: accepted at first cycle, expires TO cycles after accept
    se0 = se_seen;
    send(8'hE0, 3, "timeout prefix");
    hit = 0;
    for (int i = 1; i <= 3 * TO; i++) begin
      @(negedge clk);
      if (seq_err === 1'b1 && hit == 0) hit = i;
    end
    m_ext = 1'b0;
    m_brk = 1'b0;
    se_exp++;
    check_int("seq_err cycle", hit, TO + 1 - 3);
    check_int("seq_err count", se_seen - se0, 1);
    send(8'h1D, 1, "w after timeout");
    send(8'hF0, 1, "w brk after timeout");
    send(8'h1D, 1, "w break after timeout");

    // Byte on the expiry cycle wins
    se0 = se_seen;
    send(8'hE0, 1, "expiry prefix");
    repeat (TO - 1) @(negedge clk);
    rx_data  = 8'h75;
    rx_valid = 1'b1;
    @(negedge clk);
    model_byte(8'h75);
    check_out("byte on expiry");
    check_bit("seq_err on expiry", seq_err, 1'b0);
    rx_valid = 1'b0;
    repeat (2 * TO) @(negedge clk);
    check_int("no seq_err after expiry byte", se_seen - se0, 0);

    // Reset in the middle of a sequence
    send(8'h1D, 1, "w before reset");
    send(8'hE0, 1, "prefix before reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check_out("async reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send(8'h72, 1, "72 after reset");

    // Randomized byte stream against the model
    for (int n = 0; n < 300; n++) begin
      send(pool[$urandom_range(0, 9)], int'($urandom_range(1, 3)), "random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    check_int("total seq_err", se_seen, se_exp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_key_controller.md
Name: ps2_key_controller

Overview:
- Sits between the PS/2 byte receiver and the Pong game logic.
- Consumes the receiver's byte and completion flag, and decodes scan-code set 2 sequences (make, F0 break, E0 extended) through a prefix FSM.
- Maintains held-key state for both paddles and produces registered control levels/pulses for the game FSM: paddle directions, start and pause.

Parameters:
- TIMEOUT_CYCLES, 250000: clk cycles allowed between a prefix byte and its follow-up byte (5 ms at 50 MHz) before the FSM abandons the sequence.
- CNT_W, $clog2(TIMEOUT_CYCLES): timeout counter width.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- rx_data  input  8  last received scan-code byte; stable while rx_valid is high.
- rx_valid  input  1  receiver completion flag; a level that can stay high for multiple clk cycles.
- p1_up  output  1  player 1 paddle up (W held).
- p1_down  output  1  player 1 paddle down (S held).
- p2_up  output  1  player 2 paddle up (Up arrow held).
- p2_down  output  1  player 2 paddle down (Down arrow held).
- start_pulse  output  1  one-cycle pulse on Space make.
- paused  output  1  pause state, toggled by Esc make.
- seq_err  output  1  one-cycle pulse on prefix timeout.

Behaviour:
- Reset (rst low, async): FSM=IDLE; timeout counter=0; all held flags=0; all outputs=0; rx_valid_q=0.
- Byte accept: accept = rx_valid & ~rx_valid_q, with rx_valid_q registered each cycle. Exactly one accept per byte, regardless of how long rx_valid stays high.
- Latency: outputs update on the clk edge following the accept cycle (1 cycle).
- Scan codes: W=1D, S=1B, Space=29, Esc=76, Up=E0 75, Down=E0 72, prefixes E0/F0. All other codes are ignored, including E1.
- FSM states: IDLE, EXT, BRK, EXT_BRK.
  - IDLE: E0 -> EXT; F0 -> BRK; any other code is a make of a non-extended key; stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> EXT (counter restarts); any other code is a make of an extended key -> IDLE.
  - BRK: F0 -> BRK; any other code is a break of a non-extended key -> IDLE.
  - EXT_BRK: any code is a break of an extended key -> IDLE.
- Extended-only keys: 75/72 act only as extended codes; non-extended 75/72 (keypad) are ignored.
- Held flags: make sets the flag; break clears it.
- Timeout:
  - The counter runs only while not in IDLE and clears on every accept.
  - When it reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE, seq_err pulses, and held flags are unchanged.
  - If an accept and timeout expiry occur in the same cycle, the byte wins: it is processed in the current state and no seq_err is issued.
- Typematic repeats:
  - A repeated make of a held key causes no state change.
  - start_pulse fires only when Space transitions from not held to held.
  - paused toggles only when Esc transitions from not held to held.
- Direction resolution is per player. Default: both directions held -> both outputs 0 (neutral). Otherwise the output equals the held flag.
- Mid-sequence reset: async clear to the reset state above; the partial sequence is discarded.

Optional Feature:
- Macro: SOCD_LAST_WINS_EN.
- Defined:
  - Each player keeps a last-pressed register, updated on a make that is a not-held -> held transition.
  - Both directions held -> the last pressed direction is asserted.
  - Releasing that key while the other remains held -> the other direction asserts on the next cycle.
- Undefined: the neutral rule above applies; the last-pressed register is not generated.

Decomposition:
- Package ps2_pkg:
  - scan-code localparams: SC_EXT=E0, SC_BRK=F0, SC_W, SC_S, SC_SPACE, SC_ESC, SC_UP, SC_DOWN;
  - FSM state typedef/encoding (2 bits).
- Sub-module paddle_dir_resolver: inputs clk, rst, up_held, dn_held, up_make, dn_make; outputs dir_up, dir_dn; contains the SOCD logic. Instantiated twice, once per player.

Test Plan:
- Byte 1D with rx_valid held high for 5 cycles -> p1_up=1 exactly one cycle after the first high cycle, single accept; then F0,1D -> p1_up=0.
- E0,75 -> p2_up=1; E0,F0,75 -> p2_up=0; bare 75 -> no change on any output.
- 29 sent three times (typematic), then F0,29 -> exactly one start_pulse; 76 make/break twice -> paused 0->1->0.
- 1D and 1B both held: default -> p1_up=p1_down=0; with SOCD_LAST_WINS_EN -> p1_down=1; then F0,1B -> p1_up=1.
- E0 followed by an idle gap of TIMEOUT_CYCLES (set to 16) -> seq_err one pulse, FSM in IDLE; next byte 1D -> p1_up=1. A byte arriving on the expiry cycle -> no seq_err.
- rst low between E0 and 72 -> all outputs 0; after release, 72 alone -> no p2_down.
